// File: rtl/modulo_counter.sv
// Modulo-N sequencer counter with enable, clear, saturating load, terminal count and wrap pulse.
// Define PARAM_COUNTER_DOWN_EN to honour dir (up/down); otherwise the counter only counts up.
module modulo_counter #(
    parameter int UPPER_BOUND = 8,
    parameter int RESET_VALUE = 0,
    localparam int WIDTH = (UPPER_BOUND > 2) ? $clog2(UPPER_BOUND) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dir,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(UPPER_BOUND - 1);
    localparam logic [WIDTH-1:0] CNT_RST = WIDTH'(RESET_VALUE);

    logic [WIDTH-1:0] r_cnt;
    logic             r_wrap;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic             w_wrap_nxt;
    logic [WIDTH-1:0] w_step_val;
    logic             w_step_wrap;
    logic             w_at_max;
    logic             w_tc_hit;

    assign w_at_max = (r_cnt == CNT_MAX);

`ifdef PARAM_COUNTER_DOWN_EN
    logic w_at_zero;
    assign w_at_zero = (r_cnt == '0);
    assign w_tc_hit  = dir ? w_at_zero : w_at_max;
`else
    logic w_unused_dir;
    assign w_unused_dir = dir;
    assign w_tc_hit     = w_at_max;
`endif

    // Single enabled step; explicit wrap keeps non-power-of-two N out of N..2^WIDTH-1.
    always_comb begin
        w_step_val  = r_cnt + WIDTH'(1);
        w_step_wrap = 1'b0;
        if (w_at_max) begin
            w_step_val  = '0;
            w_step_wrap = 1'b1;
        end
`ifdef PARAM_COUNTER_DOWN_EN
        if (dir) begin
            w_step_val  = r_cnt - WIDTH'(1);
            w_step_wrap = 1'b0;
            if (w_at_zero) begin
                w_step_val  = CNT_MAX;
                w_step_wrap = 1'b1;
            end
        end
`endif
    end

    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_wrap_nxt = 1'b0;
        if (clr) begin
            w_cnt_nxt = CNT_RST;
        end else if (load) begin
            w_cnt_nxt = (load_val > CNT_MAX) ? CNT_MAX : load_val;
        end else if (en) begin
            w_cnt_nxt  = w_step_val;
            w_wrap_nxt = w_step_wrap;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt  <= CNT_RST;
            r_wrap <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_wrap <= w_wrap_nxt;
        end
    end

    assign cnt  = r_cnt;
    assign wrap = r_wrap;
    assign tc   = en & w_tc_hit;

endmodule

// File: tb/tb_modulo_counter.sv
// Self-checking bench: N=8 (reset 0) and N=5 (reset 3) counters driven in parallel,
// directed literal checks followed by randomized stimulus against a modular-arithmetic model.
module tb_modulo_counter;

    logic       clk = 1'b0;
    logic       rst, en, clr, load, dir;
    logic [2:0] lv;
    logic [2:0] cnt8, cnt5;
    logic       tc8, tc5, wrap8, wrap5;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    modulo_counter #(.UPPER_BOUND(8), .RESET_VALUE(0)) dut8 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .load_val(lv),
        .dir(dir), .cnt(cnt8), .tc(tc8), .wrap(wrap8)
    );

    modulo_counter #(.UPPER_BOUND(5), .RESET_VALUE(3)) dut5 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .load_val(lv),
        .dir(dir), .cnt(cnt5), .tc(tc5), .wrap(wrap5)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: counter value as an integer modulo N.
    int NV[2] = '{8, 5};
    int RV[2] = '{0, 3};
    int m_cnt[2];
    int m_wrap[2];
    bit m_valid = 1'b0;

    function automatic bit model_down();
`ifdef PARAM_COUNTER_DOWN_EN
        return dir;
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int n, nxt;
            n = NV[i];
            if (!rst || clr) begin
                m_cnt[i]  = RV[i];
                m_wrap[i] = 0;
            end else if (load) begin
                m_cnt[i]  = (int'(lv) < n) ? int'(lv) : n - 1;
                m_wrap[i] = 0;
            end else if (en) begin
                nxt       = m_cnt[i] + (model_down() ? -1 : 1);
                m_wrap[i] = (nxt == n || nxt == -1) ? 1 : 0;
                m_cnt[i]  = (nxt + n) % n;
            end else begin
                m_wrap[i] = 0;
            end
        end
        if (!rst) m_valid = 1'b1;
    end

    function automatic int exp_tc(input int i);
        int last;
        last = model_down() ? 0 : NV[i] - 1;
        return (en && m_cnt[i] == last) ? 1 : 0;
    endfunction

    always @(negedge clk) begin
        if (m_valid) begin
            chk("cnt8", 32'(cnt8), m_cnt[0]);
            chk("wrap8", 32'(wrap8), m_wrap[0]);
            chk("tc8", 32'(tc8), exp_tc(0));
            chk("cnt5", 32'(cnt5), m_cnt[1]);
            chk("wrap5", 32'(wrap5), m_wrap[1]);
            chk("tc5", 32'(tc5), exp_tc(1));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    int exp8[10] = '{1, 2, 3, 4, 5, 6, 7, 0, 1, 2};
    int exp5[10] = '{4, 0, 1, 2, 3, 4, 0, 1, 2, 3};
    int en6[4]   = '{1, 0, 0, 1};
    int exp6[4]  = '{3, 3, 3, 4};

    initial begin
        // Reset dominates clr/load/en.
        rst = 1'b0; en = 1'b1; clr = 1'b1; load = 1'b1; lv = 3'd5; dir = 1'b0;
        tick();
        chk("rst_cnt8", 32'(cnt8), 0);
        chk("rst_wrap8", 32'(wrap8), 0);
        chk("rst_cnt5", 32'(cnt5), 3);

        // Free count up through wraps.
        rst = 1'b1; clr = 1'b0; load = 1'b0;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("up_tc8", 32'(tc8), (k == 7) ? 1 : 0);
            tick();
            chk("up_cnt8", 32'(cnt8), exp8[k]);
            chk("up_wrap8", 32'(wrap8), (exp8[k] == 0) ? 1 : 0);
            chk("up_cnt5", 32'(cnt5), exp5[k]);
            chk("up_wrap5", 32'(wrap5), (exp5[k] == 0) ? 1 : 0);
        end

        // Enable gaps hold the count.
        for (int k = 0; k < 4; k++) begin
            en = en6[k][0];
            tick();
            chk("en_cnt8", 32'(cnt8), exp6[k]);
            chk("en_wrap8", 32'(wrap8), 0);
        end

        // Load wins over enable and saturates out-of-range values.
        en = 1'b1; load = 1'b1; lv = 3'd3;
        tick();
        chk("ld_cnt8_3", 32'(cnt8), 3);
        lv = 3'd6;
        tick();
        chk("ld_cnt8_6", 32'(cnt8), 6);
        chk("ld_cnt5_sat6", 32'(cnt5), 4);
        lv = 3'd7;
        tick();
        chk("ld_cnt8_7", 32'(cnt8), 7);
        chk("ld_cnt5_sat7", 32'(cnt5), 4);
        chk("ld_wrap5", 32'(wrap5), 0);

        // Clear wins over load.
        lv = 3'd5;
        tick();
        chk("ld_cnt8_5", 32'(cnt8), 5);
        clr = 1'b1; lv = 3'd2;
        tick();
        chk("clr_cnt8", 32'(cnt8), 0);
        chk("clr_cnt5", 32'(cnt5), 3);
        chk("clr_wrap8", 32'(wrap8), 0);
        clr = 1'b0; load = 1'b0;

        dir = 1'b1;
`ifdef PARAM_COUNTER_DOWN_EN
        #1;
        chk("dn_tc8", 32'(tc8), 1);
        tick();
        chk("dn_cnt8_7", 32'(cnt8), 7);
        chk("dn_wrap8", 32'(wrap8), 1);
        tick();
        chk("dn_cnt8_6", 32'(cnt8), 6);
        chk("dn_wrap8_off", 32'(wrap8), 0);
        tick();
        chk("dn_cnt8_5", 32'(cnt8), 5);
        chk("dn_cnt5", 32'(cnt5), 0);
`else
        #1;
        chk("nodn_tc8", 32'(tc8), 0);
        tick();
        chk("nodn_cnt8_1", 32'(cnt8), 1);
        tick();
        chk("nodn_cnt8_2", 32'(cnt8), 2);
        tick();
        chk("nodn_cnt8_3", 32'(cnt8), 3);
        chk("nodn_cnt5", 32'(cnt5), 1);
`endif

        // Randomized traffic, checked every cycle by the compare process.
        for (int k = 0; k < 3000; k++) begin
            rst  = ($urandom_range(0, 63) != 0);
            clr  = ($urandom_range(0, 15) == 0);
            load = ($urandom_range(0, 7) == 0);
            en   = ($urandom_range(0, 3) != 0);
            dir  = $urandom_range(0, 1) != 0;
            lv   = 3'($urandom_range(0, 7));
            tick();
        end

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
